// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: registered condition evaluation with valid/ready handshake.
// Optional 2-bit BHT for IF predictions, built when BRANCH_BHT_EN is defined.
module branch_resolve_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_target,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [3:0]        cond,
  input  logic              pred_taken,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              lookup_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [1:0]        out_result,
  output logic              out_mispredict,
  output logic [PC_W-1:0]   out_redirect_pc
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  logic            w_acc;
  logic            w_eq;
  logic            w_lts;
  logic            w_ltu;
  logic            w_zeq;
  logic            w_zneg;
  logic [1:0]      w_sres;
  logic [1:0]      w_ures;
  logic [1:0]      w_zres;
  logic            w_taken;
  logic [1:0]      w_result;
  logic [PC_W-1:0] w_redirect;

  logic            r_valid;
  logic            r_taken;
  logic [1:0]      r_result;
  logic            r_mispredict;
  logic [PC_W-1:0] r_redirect;

  assign in_ready = ~r_valid | out_ready;
  assign w_acc    = in_valid & in_ready & ~flush;

  assign w_eq   = (rs_data == rt_data);
  assign w_lts  = ($signed(rs_data) < $signed(rt_data));
  assign w_ltu  = (rs_data < rt_data);
  assign w_zeq  = (rs_data == '0);
  assign w_zneg = rs_data[DATA_W-1];

  assign w_sres = w_eq  ? 2'b01 : (w_lts  ? 2'b10 : 2'b11);
  assign w_ures = w_eq  ? 2'b01 : (w_ltu  ? 2'b10 : 2'b11);
  assign w_zres = w_zeq ? 2'b01 : (w_zneg ? 2'b10 : 2'b11);

  always_comb begin
    w_taken  = 1'b0;
    w_result = 2'b00;
    case (cond)
      4'd0:  begin w_taken = w_eq;             w_result = w_sres; end
      4'd1:  begin w_taken = ~w_eq;            w_result = w_sres; end
      4'd2:  begin w_taken = w_lts;            w_result = w_sres; end
      4'd3:  begin w_taken = ~w_lts;           w_result = w_sres; end
      4'd4:  begin w_taken = w_ltu;            w_result = w_ures; end
      4'd5:  begin w_taken = ~w_ltu;           w_result = w_ures; end
      4'd6:  begin w_taken = w_zneg;           w_result = w_zres; end
      4'd7:  begin w_taken = ~w_zneg;          w_result = w_zres; end
      4'd8:  begin w_taken = ~w_zneg & ~w_zeq; w_result = w_zres; end
      4'd9:  begin w_taken = w_zneg | w_zeq;   w_result = w_zres; end
      4'd10: begin w_taken = 1'b1;             w_result = w_sres; end
      default: begin
        w_taken  = 1'b0;
        w_result = 2'b00;
      end
    endcase
  end

  assign w_redirect = w_taken ? in_target : (in_pc + PC_W'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_taken      <= 1'b0;
      r_result     <= 2'b00;
      r_mispredict <= 1'b0;
      r_redirect   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_valid      <= 1'b1;
      r_taken      <= w_taken;
      r_result     <= w_result;
      r_mispredict <= w_taken ^ pred_taken;
      r_redirect   <= w_redirect;
    end else if (r_valid & out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid       = r_valid;
  assign out_taken       = r_taken;
  assign out_result      = r_result;
  assign out_mispredict  = r_mispredict;
  assign out_redirect_pc = r_redirect;

`ifdef BRANCH_BHT_EN
  logic [1:0]       r_bht [BHT_DEPTH];
  logic             w_train;
  logic [IDX_W-1:0] w_widx;
  logic [IDX_W-1:0] w_ridx;
  logic [1:0]       w_cnt;
  logic             w_unused;

  assign w_train  = w_acc & (cond <= 4'd9);
  assign w_widx   = in_pc[2 +: IDX_W];
  assign w_ridx   = lookup_pc[2 +: IDX_W];
  assign w_cnt    = r_bht[w_widx];
  assign w_unused = ^lookup_pc;

  // Lookup reads the pre-update table: same-cycle training shows next cycle.
  assign lookup_taken = r_bht[w_ridx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_train) begin
      if (w_taken) begin
        r_bht[w_widx] <= (w_cnt == 2'b11) ? 2'b11 : w_cnt + 2'b01;
      end else begin
        r_bht[w_widx] <= (w_cnt == 2'b00) ? 2'b00 : w_cnt - 2'b01;
      end
    end
  end
`else
  logic w_unused;

  assign w_unused     = ^lookup_pc;
  assign lookup_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit.
// Expectations follow BRANCH_BHT_EN the same way the design does.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [3:0]  cond;
  logic        pred_taken;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [1:0]  out_result;
  logic        out_mispredict;
  logic [31:0] out_redirect_pc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .DATA_W(32),
    .PC_W(32),
    .BHT_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_target(in_target),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .cond(cond),
    .pred_taken(pred_taken),
    .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_taken(out_taken),
    .out_result(out_result),
    .out_mispredict(out_mispredict),
    .out_redirect_pc(out_redirect_pc)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] pc, logic [31:0] tgt,
                       logic [31:0] rs, logic [31:0] rt,
                       logic [3:0] c, logic p);
    in_pc      = pc;
    in_target  = tgt;
    rs_data    = rs;
    rt_data    = rt;
    cond       = c;
    pred_taken = p;
    in_valid   = 1'b1;
  endtask

  task automatic chk_out(string tag, logic v, logic t, logic [1:0] r,
                         logic m, logic [31:0] rd);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".taken"}, 64'(out_taken), 64'(t));
    chk({tag, ".result"}, 64'(out_result), 64'(r));
    chk({tag, ".mispred"}, 64'(out_mispredict), 64'(m));
    chk({tag, ".redirect"}, 64'(out_redirect_pc), 64'(rd));
  endtask

  task automatic vec(string tag, logic [31:0] pc, logic [31:0] tgt,
                     logic [31:0] rs, logic [31:0] rt, logic [3:0] c,
                     logic p, logic t, logic [1:0] r, logic [31:0] rd);
    drive(pc, tgt, rs, rt, c, p);
    tick();
    in_valid = 1'b0;
    chk_out(tag, 1'b1, t, r, t ^ p, rd);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_pc      = '0;
    in_target  = '0;
    rs_data    = '0;
    rt_data    = '0;
    cond       = '0;
    pred_taken = 1'b0;
    lookup_pc  = 32'h40;
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("reset.lookup", 64'(lookup_taken), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);

    // PCs below avoid BHT index 0 so the 0x40 entry stays untouched.
    vec("eq", 32'h104, 32'h200, 32'd5, 32'd5, 4'd0, 1'b0,
        1'b1, 2'b01, 32'h200);
    vec("lt_s", 32'h104, 32'h210, 32'hFFFFFFFF, 32'd1, 4'd2, 1'b1,
        1'b1, 2'b10, 32'h210);
    vec("ltu", 32'h104, 32'h220, 32'hFFFFFFFF, 32'd1, 4'd4, 1'b1,
        1'b0, 2'b11, 32'h108);
    vec("gtz0", 32'h108, 32'h230, 32'd0, 32'd9, 4'd8, 1'b0,
        1'b0, 2'b01, 32'h10C);
    vec("lez0", 32'h108, 32'h240, 32'd0, 32'd9, 4'd9, 1'b0,
        1'b1, 2'b01, 32'h240);
    vec("inv15", 32'h10C, 32'h250, 32'd3, 32'd3, 4'd15, 1'b0,
        1'b0, 2'b00, 32'h110);
    vec("ne_eq", 32'h10C, 32'h260, 32'd3, 32'd3, 4'd1, 1'b1,
        1'b0, 2'b01, 32'h110);
    vec("always", 32'h110, 32'h270, 32'd1, 32'd2, 4'd10, 1'b0,
        1'b1, 2'b10, 32'h270);
    vec("ltz_neg", 32'h114, 32'h280, 32'h80000000, 32'd0, 4'd6, 1'b1,
        1'b1, 2'b10, 32'h280);
    vec("gesu_wrap", 32'hFFFFFFFC, 32'h290, 32'd1, 32'd2, 4'd5, 1'b0,
        1'b0, 2'b10, 32'h0);
    vec("ge_s", 32'h118, 32'h2A0, 32'd7, 32'hFFFFFFF0, 4'd3, 1'b0,
        1'b1, 2'b11, 32'h2A0);

    // Backpressure: A held for two cycles while B waits.
    vec("bp.A", 32'h304, 32'h3A0, 32'd4, 32'd4, 4'd0, 1'b1,
        1'b1, 2'b01, 32'h3A0);
    out_ready = 1'b0;
    drive(32'h504, 32'h600, 32'd1, 32'd2, 4'd2, 1'b0);
    #1;
    chk("bp.in_ready0", 64'(in_ready), 64'd0);
    tick();
    chk_out("bp.hold1", 1'b1, 1'b1, 2'b01, 1'b0, 32'h3A0);
    tick();
    chk_out("bp.hold2", 1'b1, 1'b1, 2'b01, 1'b0, 32'h3A0);
    chk("bp.in_ready_hold", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready1", 64'(in_ready), 64'd1);
    tick();
    chk_out("bp.B", 1'b1, 1'b1, 2'b10, 1'b1, 32'h600);
    drive(32'h508, 32'h700, 32'd1, 32'd2, 4'd1, 1'b1);
    tick();
    chk_out("bp.C", 1'b1, 1'b1, 2'b10, 1'b0, 32'h700);
    drive(32'h50C, 32'h800, 32'd9, 32'd2, 4'd2, 1'b0);
    tick();
    chk_out("bp.D", 1'b1, 1'b0, 2'b11, 1'b0, 32'h510);
    in_valid = 1'b0;
    tick();
    chk("bp.drain", 64'(out_valid), 64'd0);

    // Flush with a held result and a trainable branch at 0x40.
    vec("fl.A", 32'h604, 32'h900, 32'd2, 32'd2, 4'd0, 1'b1,
        1'b1, 2'b01, 32'h900);
    out_ready = 1'b0;
    drive(32'h40, 32'hA00, 32'd6, 32'd6, 4'd0, 1'b0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.bht", 64'(lookup_taken), 64'd0);

    // Reset mid-operation drops held result and blocks training.
    vec("rs.A", 32'h704, 32'hB00, 32'd1, 32'd1, 4'd0, 1'b1,
        1'b1, 2'b01, 32'hB00);
    drive(32'h40, 32'hC00, 32'd6, 32'd6, 4'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk_out("rs.mid", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("rs.bht", 64'(lookup_taken), 64'd0);

`ifdef BRANCH_BHT_EN
    lookup_pc = 32'h40;
    drive(32'h40, 32'hD00, 32'd1, 32'd1, 4'd0, 1'b0);
    #1;
    chk("bht.rbw", 64'(lookup_taken), 64'd0);
    tick();
    chk("bht.t1", 64'(lookup_taken), 64'd1);
    tick();
    chk("bht.t2", 64'(lookup_taken), 64'd1);
    tick();
    chk("bht.t3", 64'(lookup_taken), 64'd1);
    drive(32'h40, 32'hD00, 32'd1, 32'd1, 4'd1, 1'b0);
    tick();
    chk("bht.n1", 64'(lookup_taken), 64'd1);
    tick();
    chk("bht.n2", 64'(lookup_taken), 64'd0);
    drive(32'h40, 32'hD00, 32'd1, 32'd2, 4'd10, 1'b0);
    tick();
    chk("bht.always", 64'(lookup_taken), 64'd0);
    drive(32'h80, 32'hE00, 32'd1, 32'd1, 4'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("bht.alias80", 64'(lookup_taken), 64'd1);
    lookup_pc = 32'h80;
    #1;
    chk("bht.look80", 64'(lookup_taken), 64'd1);
    lookup_pc = 32'h44;
    #1;
    chk("bht.other", 64'(lookup_taken), 64'd0);
`else
    lookup_pc = 32'h40;
    drive(32'h40, 32'hD00, 32'd1, 32'd1, 4'd0, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    chk("static.lookup", 64'(lookup_taken), 64'd0);
    chk_out("static.out", 1'b1, 1'b1, 2'b01, 1'b1, 32'hD00);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined successor to the combinational branch comparator. Accepts one branch per cycle from the ID/EX boundary, evaluates a signed/unsigned/zero condition, registers the outcome with a valid/ready handshake, and flags mispredictions against the front-end prediction. An optional 2-bit-counter branch history table (BHT) supplies predictions to IF and is trained on every resolved conditional branch.

## Interface
- `DATA_W`, 32: operand width.
- `PC_W`, 32: PC width.
- `BHT_DEPTH`, 16: BHT entries, power of two ≥ 2; index = `pc[2 +: log2(BHT_DEPTH)]`.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: kill in-flight result and same-cycle input.
- `in_valid` in 1: branch presented.
- `in_ready` out 1: unit can accept.
- `in_pc` in PC_W: branch PC.
- `in_target` in PC_W: taken target.
- `rs_data` in DATA_W: first operand.
- `rt_data` in DATA_W: second operand (ignored for zero conditions).
- `cond` in 4: condition code.
- `pred_taken` in 1: prediction IF used for this branch.
- `lookup_pc` in PC_W: IF lookup address.
- `lookup_taken` out 1: combinational BHT prediction.
- `out_valid` out 1: resolved result held.
- `out_ready` in 1: consumer accepts.
- `out_taken` out 1: branch taken.
- `out_result` out 2: 00 default, 01 equal, 10 less, 11 greater.
- `out_mispredict` out 1: `out_taken != pred_taken`.
- `out_redirect_pc` out PC_W: `in_target` if taken, else `in_pc + 4` (mod 2^PC_W).

## Operation
- Cond codes: 0 EQ, 1 NE, 2 LT (signed), 3 GE (signed), 4 LTU, 5 GEU, 6 LTZ, 7 GEZ, 8 GTZ, 9 LEZ, 10 ALWAYS; 11–15 invalid → not taken, `out_result`=00.
- Codes 6–9 compare `rs_data` with 0, signed; rt_data ignored.
- `out_result`: compare kind per cond (unsigned for 4/5, signed otherwise); 01/10/11 for equal/less/greater; ALWAYS reports signed rs vs rt.
- Accept = `in_valid & in_ready & ~flush`.
- `in_ready = ~out_valid | out_ready` (combinational; no skid buffer).
- On accept: output register loads all `out_*` fields; `out_valid`←1.
- Output accepted (`out_valid & out_ready`) with no new accept: `out_valid`←0.
- Output stable while `out_valid & ~out_ready`.
- `flush`: `out_valid`←0 next cycle; same-cycle input dropped; takes priority over everything except `rst`.
- BHT: 2-bit saturating counters; predict taken if counter ≥ 2.
- Training on accept, cond 0–9 only: taken → +1 sat 3, not taken → −1 sat 0. ALWAYS/invalid/flushed do not train.

## Timing
- Latency 1: accepted in cycle N → `out_valid` in N+1.
- Throughput 1/cycle with `out_ready` held high.
- Reset: `out_valid`=0, `out_taken`=0, `out_result`=00, `out_mispredict`=0, `out_redirect_pc`=0; all BHT counters=01 (weakly not-taken); `lookup_taken`=0 after reset.
- BHT lookup read-before-write: same-index lookup and training in one cycle returns old value; new value visible next cycle.
- `rst` mid-operation discards held result; no training that cycle.

## Configuration
- `BRANCH_BHT_EN` defined: BHT built and trained as above.
- Undefined: no table storage; `lookup_taken` tied 0 (static not-taken); `lookup_pc` unused; all else unchanged.

## Test plan
- Reset, `rs=5 rt=5 cond=0 pred=0` → next cycle `out_valid=1 taken=1 result=01 mispredict=1 redirect=in_target`.
- `rs=32'hFFFFFFFF rt=1`: cond 2 → taken, result 10; cond 4 → not taken, result 11, redirect=`in_pc+4`.
- `rs=0`, cond 8 → not taken; cond 9 → taken; cond 15 → not taken, result 00.
- Hold `out_ready=0` two cycles with `in_valid=1` → `in_ready=0`, outputs stable; release → next branch loads following cycle; back-to-back at 1/cycle afterwards.
- `flush` with `in_valid=1` and `out_valid=1` → next cycle `out_valid=0`, BHT unchanged.
- With `BRANCH_BHT_EN`: three taken branches at PC 0x40 → `lookup_taken` for 0x40: 0 after reset, 1 after first, stays 1 (counter 3); two not-taken → 0; PC 0x80 (DEPTH 16, same index) aliases.
